// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction SRAM request/addr-ok/data-ok bus
interface pc_fetch_unit_if #(parameter int PC_WIDTH = 32);
  logic                inst_req;
  logic [PC_WIDTH-1:0] inst_addr;
  logic                inst_addr_ok;
  logic                inst_data_ok;
  logic [31:0]         inst_rdata;
  modport master(output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
  modport slave(input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: next-PC generation and single-buffer instruction fetch front end
module pc_fetch_unit #(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_ADDR = PC_WIDTH'(32'hbfc00000),
  parameter logic [PC_WIDTH-1:0] EXC_ADDR   = PC_WIDTH'(32'hbfc00380),
  parameter bit                  DELAY_SLOT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_exception,
  input  logic                i_eret,
  input  logic [PC_WIDTH-1:0] i_epc,
  input  logic                i_br_valid,
  input  logic [PC_WIDTH-1:0] i_br_pc,
  input  logic                i_is_b,
  input  logic                i_is_j,
  input  logic                i_is_jr,
  input  logic [3:0]          i_b_type,
  input  logic [15:0]         i_b_offset,
  input  logic [25:0]         i_j_index,
  input  logic [PC_WIDTH-1:0] i_rs_data,
  input  logic [PC_WIDTH-1:0] i_rt_data,
  pc_fetch_unit_if.master     imem,
  output logic                o_fs_valid,
  output logic [PC_WIDTH-1:0] o_fs_pc,
  output logic [31:0]         o_fs_inst,
  input  logic                i_ds_allowin
);
  localparam logic [1:0] S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2;
  logic [1:0]          r_state;
  logic [PC_WIDTH-1:0] r_fetch_pc, r_issued_pc, r_pend_pc, r_fs_pc;
  logic                r_pend_valid, r_ds_pend, r_discard, r_fs_valid;
  logic [31:0]         r_fs_inst;
  logic                w_eq, w_neg, w_zero, w_cond, w_b_taken, w_taken, w_flush, w_accept;
  logic                w_data, w_take, w_handoff, w_outstanding, w_ds_new, w_pv, w_dp;
  logic [PC_WIDTH-1:0] w_seq_br, w_b_tgt, w_j_tgt, w_tgt, w_pp, w_next_pc;
  assign w_eq   = i_rs_data == i_rt_data;
  assign w_neg  = i_rs_data[PC_WIDTH-1];
  assign w_zero = ~|i_rs_data;
  assign w_cond = (i_b_type == 4'd0) ? ~w_eq :
                  (i_b_type == 4'd1) ? w_eq :
                  (i_b_type == 4'd2 || i_b_type == 4'd7) ? ~w_neg :
                  (i_b_type == 4'd3) ? ~w_neg & ~w_zero :
                  (i_b_type == 4'd4) ? w_neg | w_zero :
                  (i_b_type == 4'd5 || i_b_type == 4'd6) ? w_neg : 1'b0;
  assign w_seq_br  = i_br_pc + PC_WIDTH'(4);
  assign w_b_tgt   = w_seq_br + {{(PC_WIDTH-18){i_b_offset[15]}}, i_b_offset, 2'b00};
  assign w_j_tgt   = {w_seq_br[PC_WIDTH-1:28], i_j_index, 2'b00};
  assign w_b_taken = i_is_b & w_cond;
  assign w_taken   = i_br_valid & (w_b_taken | i_is_jr | i_is_j);
  assign w_tgt     = w_b_taken ? w_b_tgt : i_is_jr ? i_rs_data : w_j_tgt;
  assign w_flush   = i_exception | i_eret;
  assign w_accept  = (r_state == S_REQ) & imem.inst_addr_ok;
  assign w_data    = (r_state == S_WAIT) & imem.inst_data_ok;
  assign w_take    = w_data & ~r_discard;
  assign w_handoff = (r_state == S_HOLD) & r_fs_valid & i_ds_allowin;
  assign w_outstanding = w_accept | ((r_state == S_WAIT) & ~imem.inst_data_ok);
  // a redirect waits only while its delay slot has still to be requested
  assign w_ds_new  = DELAY_SLOT & (r_issued_pc == i_br_pc);
  assign w_pv      = w_taken | r_pend_valid;
  assign w_pp      = w_taken ? w_tgt : r_pend_pc;
  assign w_dp      = w_taken ? w_ds_new : r_ds_pend;
  assign w_next_pc = w_accept ? (w_pv ? w_pp : r_fetch_pc + PC_WIDTH'(4)) :
                     (w_pv & ~w_dp) ? w_pp : r_fetch_pc;
  assign imem.inst_req  = (r_state == S_REQ) & ~reset;
  assign imem.inst_addr = r_fetch_pc;
  assign o_fs_valid = r_fs_valid;
  assign o_fs_pc    = r_fs_pc;
  assign o_fs_inst  = r_fs_inst;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_fetch_pc   <= RESET_ADDR;
      r_issued_pc  <= '0;
      r_pend_pc    <= '0;
      r_pend_valid <= 1'b0;
      r_ds_pend    <= 1'b0;
      r_discard    <= 1'b0;
      r_fs_valid   <= 1'b0;
      r_fs_pc      <= '0;
      r_fs_inst    <= '0;
    end else if (w_flush) begin
      r_fetch_pc   <= i_exception ? EXC_ADDR : i_epc;
      r_pend_valid <= 1'b0;
      r_ds_pend    <= 1'b0;
      r_fs_valid   <= 1'b0;
      r_discard    <= w_outstanding;
      r_state      <= w_outstanding ? S_WAIT : S_REQ;
      if (w_accept) r_issued_pc <= r_fetch_pc;
    end else begin
      r_fetch_pc   <= w_next_pc;
      r_pend_pc    <= w_pp;
      r_pend_valid <= w_pv & w_dp & ~w_accept;
      r_ds_pend    <= w_pv & w_dp & ~w_accept;
      r_discard    <= r_discard & ~w_data;
      r_fs_valid   <= w_take | (r_fs_valid & ~w_handoff);
      r_state      <= w_accept ? S_WAIT : w_take ? S_HOLD : (w_data | w_handoff) ? S_REQ : r_state;
      if (w_accept) r_issued_pc <= r_fetch_pc;
      if (w_take) r_fs_pc <= r_issued_pc;
      if (w_take) r_fs_inst <= imem.inst_rdata;
    end
  end
endmodule
